uart_rx_fsm: RTL and testbench

Receive-side controller of the UART, sitting directly upstream of the stop-bit checker. It synchronises the serial line, detects and qualifies the start bit, and samples every bit with a 3-point majority vote on a 16x oversampling tick. It assembles LSB-first data and checks optional parity. At the stop bit it drives `sampled_bit` and a one-cycle `stop_check_en` to the stop-bit checker, and presents the received word with a valid pulse.

---
 rtl/uart_rx_fsm.sv | 119 +++++++++++
 tb/tb_uart_rx_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive controller with 2-flop sync, start qualification, 3-point majority sampling and parity check
//   clk, rst        : clock, synchronous active-high reset
//   baud_tick       : one-clk pulse at 16x baud
//   rx_in           : asynchronous serial line, idle high
//   parity_en/odd   : parity presence and sense, latched at start detection
//   sampled_bit     : majority vote of the most recent bit
//   stop_check_en   : one-clk pulse when sampled_bit holds the stop vote
//   rx_data/rx_valid: received word and its update pulse
//   parity_error    : parity result of the last frame
//   busy            : high outside IDLE
module uart_rx_fsm #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 sampled_bit,
   output logic                 stop_check_en,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_error,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] TOP  = 4'(OVERSAMPLE - 1);
   state_t               state;
   logic [1:0]           sync;
   logic [1:0]           smp;
   logic [3:0]           cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 p_en;
   logic                 p_odd;
   logic                 perr;
   logic                 rx_s;
   logic                 vote;
   assign rx_s = sync[1];
   // third sample is taken live on the tick-9 edge
   assign vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sync          <= 2'b11;
         smp           <= 2'b11;
         cnt           <= 4'd0;
         idx           <= 4'd0;
         shreg         <= '0;
         p_en          <= 1'b0;
         p_odd         <= 1'b0;
         perr          <= 1'b0;
         sampled_bit   <= 1'b1;
         stop_check_en <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         parity_error  <= 1'b0;
      end else begin
         sync          <= {sync[0], rx_in};
         stop_check_en <= 1'b0;
         rx_valid      <= 1'b0;
         if (baud_tick) begin
            if (state == IDLE) begin
               // the detecting tick is tick 0 of the start bit, so the next tick is tick 1
               if (!rx_s) begin
                  state <= START;
                  cnt   <= 4'd1;
                  idx   <= 4'd0;
                  p_en  <= parity_en;
                  p_odd <= parity_odd;
               end
            end else begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd7) smp[0] <= rx_s;
               if (cnt == 4'd8) smp[1] <= rx_s;
               if (cnt == 4'd9) sampled_bit <= vote;
               case (state)
                  START: begin
                     if (cnt == 4'd9 && vote) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                     end else if (cnt == TOP) state <= DATA;
                  end
                  DATA: begin
                     if (cnt == 4'd9) shreg <= {vote, shreg[DATA_BITS-1:1]};
                     if (cnt == TOP) begin
                        if (idx == LAST) state <= p_en ? PARITY : STOP;
                        else idx <= idx + 4'd1;
                     end
                  end
                  PARITY: begin
                     if (cnt == 4'd9) perr <= ((^shreg) ^ vote) != p_odd;
                     if (cnt == TOP) state <= STOP;
                  end
                  STOP: begin
                     // leave at the stop vote so a new start edge can land in the back half of the stop bit
                     if (cnt == 4'd9) begin
                        stop_check_en <= 1'b1;
                        rx_valid      <= 1'b1;
                        rx_data       <= shreg;
                        parity_error  <= p_en & perr;
                        state         <= IDLE;
                        cnt           <= 4'd0;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     cnt   <= 4'd0;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed and randomized frames checked against a tick-level line model
module tb_uart_rx_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx_in = 1'b1;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       sampled_bit;
   logic       stop_check_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_error;
   logic       busy;
   int         nvec = 0;
   int         nerr = 0;
   int         per = 4;
   int         vcnt = 0;
   int         scnt = 0;
   int         frames = 0;
   logic [7:0] last_data = 8'h00;

   uart_rx_fsm dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in),
      .parity_en(parity_en), .parity_odd(parity_odd), .sampled_bit(sampled_bit),
      .stop_check_en(stop_check_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_error(parity_error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) vcnt++;
      if (stop_check_en) scnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // line value v is presented for one tick period; returns just after the edge that consumes the tick
   task automatic tick(input logic v);
      rx_in = v;
      repeat (per - 1) begin
         @(posedge clk);
         #1;
      end
      baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
   endtask

   function automatic logic maj(input logic a, input logic b, input logic c);
      return (int'(a) + int'(b) + int'(c)) >= 2;
   endfunction

   // builds the frame tick by tick, forces up to two tick slots low, predicts the result from
   // the line values at ticks 7..9 of each bit, and checks outputs on the stop-vote tick
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stopv, input int f0, input int f1);
      logic       ln[$];
      logic [7:0] ed;
      logic       ep;
      logic       es;
      int         s;
      int         last;
      for (int i = 0; i < 16; i++) ln.push_back(1'b0);
      for (int b = 0; b < 8; b++) for (int i = 0; i < 16; i++) ln.push_back(d[b]);
      if (pen) for (int i = 0; i < 16; i++) ln.push_back(pbit);
      for (int i = 0; i < 16; i++) ln.push_back(stopv);
      if (f0 >= 0) ln[f0] = 1'b0;
      if (f1 >= 0) ln[f1] = 1'b0;
      for (int b = 0; b < 8; b++) begin
         s = 16 * (b + 1);
         ed[b] = maj(ln[s+7], ln[s+8], ln[s+9]);
      end
      s = 16 * 9;
      ep = pen ? (((^ed) ^ maj(ln[s+7], ln[s+8], ln[s+9])) != podd) : 1'b0;
      s = 16 * (9 + int'(pen));
      es = maj(ln[s+7], ln[s+8], ln[s+9]);
      last = s + 9;
      parity_en = pen;
      parity_odd = podd;
      for (int i = 0; i <= last; i++) begin
         tick(ln[i]);
         if (i == 0) chk("busy_start", busy, 1'b1);
         if (i == 1) begin
            parity_en = ~pen;
            parity_odd = ~podd;
         end
      end
      frames++;
      chk("rx_valid", rx_valid, 1'b1);
      chk("stop_check_en", stop_check_en, 1'b1);
      chk("sampled_bit", sampled_bit, es);
      chk("rx_data", rx_data, ed);
      chk("parity_error", parity_error, ep);
      chk("busy_end", busy, 1'b0);
      @(posedge clk);
      #1;
      chk("valid_count", vcnt, frames);
      chk("sce_count", scnt, frames);
      last_data = ed;
   endtask

   initial begin
      logic [7:0] d;
      logic       pen;
      logic       podd;
      logic       pbit;
      int         b;
      int         f1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sampled_bit", sampled_bit, 1'b1);
      chk("rst_sce", stop_check_en, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_parity_error", parity_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (3) tick(1'b1);
      chk("idle_busy", busy, 1'b0);

      per = 16;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      repeat (4) tick(1'b1);
      per = 4;

      send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
      repeat (2) tick(1'b1);
      send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
      repeat (2) tick(1'b1);

      for (int i = 0; i < 10; i++) tick(i < 4 ? 1'b0 : 1'b1);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_sampled_bit", sampled_bit, 1'b1);
      repeat (20) tick(1'b1);
      chk("glitch_valid_count", vcnt, frames);
      chk("glitch_sce_count", scnt, frames);
      chk("glitch_hold_data", rx_data, last_data);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      repeat (2) tick(1'b1);

      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      repeat (8) tick(1'b1);
      chk("stop0_no_restart", busy, 1'b0);

      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16 + 8, -1);
      repeat (2) tick(1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16 + 8, 16 + 9);
      repeat (2) tick(1'b1);

      d = 8'h81;
      for (int i = 0; i < 16 * 5 + 5; i++) tick(i < 16 ? 1'b0 : d[i/16-1]);
      rx_in = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rx_data", rx_data, 8'h00);
      chk("midrst_sampled_bit", sampled_bit, 1'b1);
      chk("midrst_parity_error", parity_error, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      repeat (2) tick(1'b1);

      for (int k = 0; k < 6; k++) begin
         per = 3 + $urandom_range(0, 3);
         d = 8'($urandom);
         pen = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         pbit = (^d) ^ podd ^ 1'($urandom_range(0, 1));
         b = $urandom_range(1, 8);
         f1 = $urandom_range(0, 1) ? -1 : 16 * b + 7 + $urandom_range(0, 2);
         send_frame(d, pen, podd, pbit, 1'b1, 16 * b + 7 + $urandom_range(0, 2), f1);
         repeat ($urandom_range(0, 3)) tick(1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
